// File: rtl/mask_gen_vga_ctrl.sv
// Sequencer for the mask_generation_VGA datapath: accepts a configuration,
// resets and serially loads the generator, then steps it one row per line request.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a configuration, generator clock gated
// CLEAR     | one-cycle synchronous soft reset of the generator
// LOAD      | serial pattern shift (PAT_LEN bits, or 1 cycle for type 11)
// WAIT_LINE | generator parked, waiting for line_req
// STEP      | generator clocked until it reports a valid row (or times out)
module mask_gen_vga_ctrl #(
    parameter int PAT_LEN = 32,
    parameter int ROWS    = 480,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [1:0]         cfg_mask_type,
    input  logic [4:0]         cfg_pattern_w,
    input  logic [7:0]         cfg_rep_pattern,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic               stop,
    input  logic               line_req,
    output logic               mg_clk_en,
    output logic               mg_rst_n,
    output logic               mg_load_pattern,
    output logic               mg_pattern,
    output logic [4:0]         mg_pattern_w,
    output logic [7:0]         mg_repeated_pattern,
    output logic [1:0]         mg_mask_type,
    input  logic               mg_rp_valid,
    output logic               row_strobe,
    output logic [8:0]         row_idx,
    output logic               frame_done,
    output logic               busy,
    output logic               err_overrun,
    output logic               err_timeout
);

    localparam int LW = $clog2(PAT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        LOAD      = 3'd2,
        WAIT_LINE = 3'd3,
        STEP      = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic [LW-1:0]      load_cnt_q, load_cnt_d;
    logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic [8:0]         row_idx_q, row_idx_d;
    logic [1:0]         type_q, type_d;
    logic [4:0]         width_q, width_d;
    logic [7:0]         rep_q, rep_d;
    logic               ovr_q, ovr_d;
    logic               tmo_err_q, tmo_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pat_q      <= '0;
            load_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            row_idx_q  <= '0;
            type_q     <= '0;
            width_q    <= '0;
            rep_q      <= '0;
            ovr_q      <= 1'b0;
            tmo_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            load_cnt_q <= load_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            row_idx_q  <= row_idx_d;
            type_q     <= type_d;
            width_q    <= width_d;
            rep_q      <= rep_d;
            ovr_q      <= ovr_d;
            tmo_err_q  <= tmo_err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pat_d           = pat_q;
        load_cnt_d      = load_cnt_q;
        tmo_cnt_d       = tmo_cnt_q;
        row_idx_d       = row_idx_q;
        type_d          = type_q;
        width_d         = width_q;
        rep_d           = rep_q;
        tmo_err_d       = tmo_err_q;
        ovr_d           = ovr_q | (line_req && (state_q != WAIT_LINE));
        cfg_ready       = 1'b0;
        mg_clk_en       = 1'b0;
        mg_rst_n        = 1'b1;
        mg_load_pattern = 1'b0;
        mg_pattern      = 1'b0;
        row_strobe      = 1'b0;
        frame_done      = 1'b0;

        case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    type_d     = cfg_mask_type;
                    width_d    = cfg_pattern_w;
                    rep_d      = cfg_rep_pattern;
                    pat_d      = cfg_pattern;
                    load_cnt_d = LW'(PAT_LEN - 1);
                    row_idx_d  = '0;
                    ovr_d      = 1'b0;
                    tmo_err_d  = 1'b0;
                    state_d    = CLEAR;
                end
            end
            CLEAR: begin
                mg_rst_n  = 1'b0;
                mg_clk_en = 1'b1;
                state_d   = LOAD;
            end
            LOAD: begin
                mg_clk_en       = 1'b1;
                mg_load_pattern = 1'b1;
                mg_pattern      = (type_q == 2'b11) ? 1'b0 : pat_q[PAT_LEN-1];
                pat_d           = {pat_q[PAT_LEN-2:0], 1'b0};
                if ((type_q == 2'b11) || (load_cnt_q == '0)) begin
                    state_d = WAIT_LINE;
                end else begin
                    load_cnt_d = load_cnt_q - LW'(1);
                end
            end
            WAIT_LINE: begin
                if (line_req) begin
                    tmo_cnt_d = TW'(TIMEOUT - 1);
                    state_d   = STEP;
                end
            end
            STEP: begin
                if (mg_rp_valid) begin
                    row_strobe = 1'b1;
                    state_d    = WAIT_LINE;
                    if (row_idx_q == 9'(ROWS - 1)) begin
                        frame_done = 1'b1;
                        row_idx_d  = '0;
                    end else begin
                        row_idx_d  = row_idx_q + 9'd1;
                    end
                end else begin
                    mg_clk_en = 1'b1;
                    // Terminal count lands on the TIMEOUT-th enabled cycle.
                    if (tmo_cnt_q == '0) begin
                        tmo_err_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q - TW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides whatever the active state decided this cycle.
        if (stop && (state_q != IDLE)) begin
            state_d         = IDLE;
            row_idx_d       = row_idx_q;
            tmo_err_d       = tmo_err_q;
            mg_clk_en       = 1'b0;
            mg_load_pattern = 1'b0;
            mg_pattern      = 1'b0;
            row_strobe      = 1'b0;
            frame_done      = 1'b0;
        end
    end

    assign mg_pattern_w        = width_q;
    assign mg_repeated_pattern = rep_q;
    assign mg_mask_type        = type_q;
    assign row_idx             = row_idx_q;
    assign busy                = (state_q != IDLE);
    assign err_overrun         = ovr_q;
    assign err_timeout         = tmo_err_q;

endmodule

// File: tb/tb_mask_gen_vga_ctrl.sv
// Directed bench for mask_gen_vga_ctrl with a small behavioural generator
// that raises mg_rp_valid a programmable number of enabled STEP cycles later.
module tb_mask_gen_vga_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_mask_type;
    logic [4:0]  cfg_pattern_w;
    logic [7:0]  cfg_rep_pattern;
    logic [31:0] cfg_pattern;
    logic        stop;
    logic        line_req;
    logic        mg_clk_en;
    logic        mg_rst_n;
    logic        mg_load_pattern;
    logic        mg_pattern;
    logic [4:0]  mg_pattern_w;
    logic [7:0]  mg_repeated_pattern;
    logic [1:0]  mg_mask_type;
    logic        mg_rp_valid;
    logic        row_strobe;
    logic [8:0]  row_idx;
    logic        frame_done;
    logic        busy;
    logic        err_overrun;
    logic        err_timeout;

    int checks   = 0;
    int failures = 0;
    int rp_delay = 1;
    bit rp_never = 1'b0;
    int en_cnt   = 0;

    localparam logic [33:0] RST_VEC = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0, 2'd0,
                                       1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    mask_gen_vga_ctrl dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .cfg_valid           (cfg_valid),
        .cfg_ready           (cfg_ready),
        .cfg_mask_type       (cfg_mask_type),
        .cfg_pattern_w       (cfg_pattern_w),
        .cfg_rep_pattern     (cfg_rep_pattern),
        .cfg_pattern         (cfg_pattern),
        .stop                (stop),
        .line_req            (line_req),
        .mg_clk_en           (mg_clk_en),
        .mg_rst_n            (mg_rst_n),
        .mg_load_pattern     (mg_load_pattern),
        .mg_pattern          (mg_pattern),
        .mg_pattern_w        (mg_pattern_w),
        .mg_repeated_pattern (mg_repeated_pattern),
        .mg_mask_type        (mg_mask_type),
        .mg_rp_valid         (mg_rp_valid),
        .row_strobe          (row_strobe),
        .row_idx             (row_idx),
        .frame_done          (frame_done),
        .busy                (busy),
        .err_overrun         (err_overrun),
        .err_timeout         (err_timeout)
    );

    always #5 clk = ~clk;

    // Generator model: counts enabled cycles outside CLEAR/LOAD.
    always @(posedge clk) begin
        if (!busy || row_strobe) begin
            en_cnt      <= 0;
            mg_rp_valid <= 1'b0;
        end else if (mg_clk_en && mg_rst_n && !mg_load_pattern && !mg_rp_valid) begin
            if (!rp_never && (en_cnt + 1 >= rp_delay)) mg_rp_valid <= 1'b1;
            en_cnt <= en_cnt + 1;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  typ;
        logic [4:0]  w;
        logic [7:0]  rep;
        logic [31:0] pat;
        int          n_load;
        int          delay;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [33:0] snap();
        return {cfg_ready, mg_clk_en, mg_rst_n, mg_load_pattern, mg_pattern, mg_pattern_w,
                mg_repeated_pattern, mg_mask_type, row_strobe, row_idx, frame_done, busy,
                err_overrun, err_timeout};
    endfunction

    task automatic go_idle();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic do_cfg(input logic [1:0] typ, input logic [4:0] w, input logic [7:0] rep,
                          input logic [31:0] pat, input int n_load,
                          input int lreq_at, input int stop_at);
        logic exp_bit;
        go_idle();
        cfg_mask_type   = typ;
        cfg_pattern_w   = w;
        cfg_rep_pattern = rep;
        cfg_pattern     = pat;
        cfg_valid       = 1'b1;
        @(negedge clk);
        chk("accept_ready", {cfg_ready, busy}, 2'b10);
        step();
        cfg_valid       = 1'b0;
        cfg_mask_type   = ~typ;
        cfg_pattern_w   = ~w;
        cfg_rep_pattern = ~rep;
        cfg_pattern     = ~pat;
        @(negedge clk);
        chk("clear_ctrl", {mg_rst_n, mg_clk_en, mg_load_pattern, cfg_ready, busy}, 5'b01001);
        chk("clear_errs", {err_overrun, err_timeout, row_idx}, 11'd0);
        chk("cfg_regs", {mg_mask_type, mg_pattern_w, mg_repeated_pattern}, {typ, w, rep});
        step();
        for (int i = 0; i < n_load; i++) begin
            line_req = (i == lreq_at);
            stop     = (i == stop_at);
            @(negedge clk);
            if (stop) begin
                chk("stop_load_ctrl", {mg_load_pattern, mg_clk_en, row_strobe}, 3'b000);
            end else begin
                exp_bit = (typ == 2'b11) ? 1'b0 : pat[31-i];
                chk("load_ctrl", {mg_load_pattern, mg_clk_en, mg_rst_n, cfg_ready}, 4'b1110);
                chk($sformatf("load_bit%0d", i), mg_pattern, exp_bit);
            end
            step();
            line_req = 1'b0;
            if (i == stop_at) begin
                stop = 1'b0;
                @(negedge clk);
                chk("stop_to_idle", {busy, cfg_ready, mg_clk_en, mg_load_pattern}, 4'b0100);
                step();
                return;
            end
        end
        @(negedge clk);
        chk("load_end", {mg_load_pattern, mg_clk_en, busy, cfg_ready}, 4'b0010);
        chk("cfg_stable", {mg_mask_type, mg_pattern_w, mg_repeated_pattern}, {typ, w, rep});
        step();
    endtask

    task automatic do_line(input int exp_idx, input bit exp_fd, input int ov_at);
        bit got = 1'b0;
        line_req = 1'b1;
        @(negedge clk);
        step();
        line_req = 1'b0;
        for (int k = 0; k < 100; k++) begin
            line_req = (k == ov_at);
            @(negedge clk);
            if (row_strobe) begin
                got = 1'b1;
                chk($sformatf("row_idx_%0d", exp_idx), row_idx, exp_idx);
                chk($sformatf("frame_done_%0d", exp_idx), {frame_done, mg_clk_en}, {exp_fd, 1'b0});
            end else if (frame_done) begin
                chk("frame_done_without_strobe", frame_done, 1'b0);
            end
            step();
            if (got) break;
        end
        line_req = 1'b0;
        if (!got) chk("row_strobe_wait", 1'b0, 1'b1);
    endtask

    task automatic no_strobe(input int n);
        bit seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (row_strobe) seen = 1'b1;
            step();
        end
        chk("no_extra_strobe", seen, 1'b0);
    endtask

    vec_t vecs[4];
    int   n_en;
    bit   seen_s;

    initial begin
        vecs[0] = '{typ: 2'b00, w: 5'b01011, rep: 8'h00, pat: 32'h03D0A052, n_load: 32, delay: 1};
        vecs[1] = '{typ: 2'b11, w: 5'b00000, rep: 8'hAF, pat: 32'hFFFFFFFF, n_load: 1,  delay: 1};
        vecs[2] = '{typ: 2'b01, w: 5'b10101, rep: 8'h5A, pat: 32'hA5A50F0F, n_load: 32, delay: 2};
        vecs[3] = '{typ: 2'b10, w: 5'b11111, rep: 8'h11, pat: 32'h80000001, n_load: 32, delay: 3};

        rst_n = 1'b0; cfg_valid = 1'b0; cfg_mask_type = '0; cfg_pattern_w = '0;
        cfg_rep_pattern = '0; cfg_pattern = '0; stop = 1'b0; line_req = 1'b0;
        mg_rp_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_values", snap(), RST_VEC);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_reset_release", snap(), RST_VEC);
        step();

        foreach (vecs[v]) begin
            rp_delay = vecs[v].delay;
            do_cfg(vecs[v].typ, vecs[v].w, vecs[v].rep, vecs[v].pat, vecs[v].n_load, -1, -1);
            do_line(0, 1'b0, -1);
            do_line(1, 1'b0, -1);
        end

        // Full frame plus one wrap row
        rp_delay = 2;
        do_cfg(2'b10, 5'd7, 8'h3C, 32'h12345678, 32, -1, -1);
        for (int r = 0; r < 481; r++) begin
            do_line(r % 480, (r == 479), -1);
            repeat (15) step();
        end

        // Overruns: during LOAD, coincident with STEP completion, mid STEP
        rp_delay = 1;
        do_cfg(2'b00, 5'd3, 8'h00, 32'hDEADBEEF, 32, 3, -1);
        chk("overrun_load", err_overrun, 1'b1);
        no_strobe(5);
        do_line(0, 1'b0, -1);
        chk("overrun_sticky", err_overrun, 1'b1);
        do_cfg(2'b00, 5'd3, 8'h00, 32'hDEADBEEF, 32, -1, -1);
        do_line(0, 1'b0, 1);
        chk("overrun_same_cycle", {err_overrun, busy}, 2'b11);
        no_strobe(6);
        rp_delay = 3;
        do_cfg(2'b01, 5'd4, 8'h00, 32'h0F0F0F0F, 32, -1, -1);
        do_line(0, 1'b0, 1);
        chk("overrun_mid_step", err_overrun, 1'b1);
        no_strobe(8);

        // Timeout
        rp_never = 1'b1;
        do_cfg(2'b11, 5'd1, 8'h81, 32'h0, 1, -1, -1);
        line_req = 1'b1;
        @(negedge clk);
        step();
        line_req = 1'b0;
        n_en = 0;
        seen_s = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (row_strobe) seen_s = 1'b1;
            if (!busy) break;
            if (mg_clk_en) n_en++;
            step();
        end
        step();
        chk("timeout_cycles", n_en, 64);
        chk("timeout_flags", {err_timeout, busy, cfg_ready, seen_s}, 4'b1010);
        rp_never = 1'b0;

        // Stop at LOAD bit 10 keeps sticky overrun; new cfg reloads from bit 31
        do_cfg(2'b00, 5'd9, 8'h00, 32'hC0FFEE11, 32, 5, 10);
        chk("stop_keeps_err", {err_overrun, busy}, 2'b10);
        rp_delay = 1;
        do_cfg(2'b00, 5'd9, 8'h00, 32'hC0FFEE11, 32, -1, -1);
        do_line(0, 1'b0, -1);

        // Asynchronous reset in STEP
        rp_delay = 6;
        line_req = 1'b1;
        @(negedge clk);
        step();
        line_req = 1'b0;
        step();
        @(negedge clk);
        chk("in_step", {busy, mg_clk_en}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("async_reset", snap(), RST_VEC);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", snap(), RST_VEC);
        step();
        rp_delay = 2;
        do_cfg(2'b01, 5'd2, 8'hA0, 32'h96C3F00D, 32, -1, -1);
        do_line(0, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
